i2c_reg_arbiter: RTL
====================

// Module: i2c_reg_arbiter
// PURPOSE
//  Shares the single register-bank port between two masters: the I2C frame-bridge path
//  (non-stallable wr_en/rd_en pulses) and a local host (req/gnt handshake).
//  - Buffers one I2C access and issues it at the next free slot.
//  - Round-robins between the two masters, sequences reads through a fixed read latency
//    and returns the read data to the master that issued the read.
// PARAMETERS
//  ADDR_W     16      register address width
//  DATA_W     32      register data width
//  RD_LAT     1       cycles from reg_rd_en to valid reg_rdata; legal 1..4
//  PROT_BASE  16'hF000 first I2C-protected address (used only with I2C_WR_PROTECT_EN)
// PORTS
//  clk        in   1       single clock
//  rst_n      in   1       async active-low reset
//  i2c_addr   in   ADDR_W  I2C-side address, sampled on a strobe
//  i2c_wdata  in   DATA_W  I2C-side write data, sampled on i2c_wr_en
//  i2c_wr_en  in   1       1-cycle write strobe from the bridge
//  i2c_rd_en  in   1       1-cycle read strobe from the bridge
//  i2c_rdata  out  DATA_W  last I2C read data; held until the next I2C read completes
//  i2c_rvalid out  1       1-cycle pulse when i2c_rdata updates
//  i2c_busy   out  1       I2C access pending or in flight
//  i2c_ovf    out  1       sticky: I2C strobe dropped (slot full or wr+rd together)
//  host_req   in   1       host request; hold req/we/addr/wdata stable until host_gnt
//  host_we    in   1       1=write, 0=read
//  host_addr  in   ADDR_W  host address
//  host_wdata in   DATA_W  host write data
//  host_gnt   out  1       1-cycle pulse in the host's ISSUE cycle
//  host_rdata out  DATA_W  host read data; held until the next host read completes
//  host_rvalid out 1       1-cycle pulse when host_rdata updates
//  reg_addr   out  ADDR_W  register-bank address
//  reg_wdata  out  DATA_W  register-bank write data
//  reg_wr_en  out  1       1-cycle write strobe
//  reg_rd_en  out  1       1-cycle read strobe
//  reg_rdata  in   DATA_W  bank read data, valid RD_LAT cycles after reg_rd_en
// BEHAVIOUR
//  - Reset: all outputs 0; pending slot empty; FSM IDLE; last_owner=HOST (first tie -> I2C).
//    Reset mid-access aborts it; no rvalid is produced.
//  - I2C capture: an i2c_wr_en or i2c_rd_en strobe loads {op,addr,wdata} into a 1-entry slot.
//    - Strobe while the slot is full -> dropped, i2c_ovf set.
//    - Strobe in the same cycle the slot is consumed -> accepted, no ovf.
//    - wr_en and rd_en high together -> ignored, i2c_ovf set.
//    - i2c_ovf clears only on reset.
//  - FSM: IDLE -> ISSUE -> (read) RDWAIT -> IDLE;  (write) ISSUE -> IDLE.
//  - IDLE, edge T: candidates are slot-valid and host_req.
//    - One candidate: it wins.
//    - Both: the master != last_owner wins.
//    - The winner's op/addr/data is registered and last_owner is updated.
//    - If the I2C slot wins, it is consumed at this edge.
//  - ISSUE (cycle T+1): reg_addr/reg_wdata driven, exactly one of reg_wr_en/reg_rd_en=1.
//    host_gnt=1 if the host owns the access. reg_addr/reg_wdata hold their value in other states.
//  - RDWAIT: counts RD_LAT cycles. reg_rdata is captured at the edge ending cycle T+1+RD_LAT.
//    Then the owner's rdata register updates and its rvalid pulses for 1 cycle (the IDLE cycle).
//  - Throughput: write every 2 cycles; read every 2+RD_LAT cycles; never two strobes in a cycle.
//  - i2c_busy = slot valid | (FSM != IDLE & owner==I2C).
// CONFIGURATION
//  I2C_WR_PROTECT_EN defined:
//   - I2C writes with addr >= PROT_BASE are accepted into the slot but never drive reg_wr_en.
//   - The slot is consumed in IDLE without a grant and i2c_ovf is set.
//   - I2C reads and host writes are unaffected.
//  Undefined: no address filtering; PROT_BASE unused.
// TESTING
//  1 I2C write 0x0010<=0xDEADBEEF, host idle -> reg_wr_en one cycle later with those values; i2c_busy falls.
//  2 RD_LAT=2; host read 0x0004, bank returns 0x12345678 -> host_gnt with reg_rd_en; host_rvalid 4 cycles after the decision edge, host_rdata=0x12345678.
//  3 host_req and I2C slot both pending from reset -> I2C issues first, host next. Repeat both -> order alternates.
//  4 Two I2C strobes 1 cycle apart while a host read is in RDWAIT -> second dropped, i2c_ovf=1 until reset, first issues later.
//  5 Assert rst_n low during RDWAIT -> all outputs 0 at once, no rvalid after release.
//  6 I2C_WR_PROTECT_EN: I2C write 0xF004 -> no reg_wr_en, i2c_ovf=1. I2C read 0xF004 -> issues normally.

Source files
------------

// File: rtl/i2c_reg_arbiter.sv
// Shares one register-bank port between the I2C bridge (1-entry strobe slot) and a local host (req/gnt).
// Optional I2C write protection above PROT_BASE is enabled by defining I2C_WR_PROTECT_EN.
module i2c_reg_arbiter #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       RD_LAT    = 1,
  parameter logic [ADDR_W-1:0] PROT_BASE = 16'hF000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  input  logic              i2c_wr_en,
  input  logic              i2c_rd_en,
  output logic [DATA_W-1:0] i2c_rdata,
  output logic              i2c_rvalid,
  output logic              i2c_busy,
  output logic              i2c_ovf,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rdata
);

  localparam int unsigned CNT_W = 2;
`ifdef I2C_WR_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  state_t             state;
  logic               slot_v;
  logic               slot_we;
  logic [ADDR_W-1:0]  slot_addr;
  logic [DATA_W-1:0]  slot_wdata;
  logic               own_host;
  logic               last_host;
  logic [CNT_W-1:0]   cnt;

  logic idle;
  logic slot_prot;
  logic i2c_cand;
  logic pick_i2c;
  logic pick_host;
  logic slot_take;
  logic strobe_one;
  logic strobe_both;

  // Arbitration: a lone candidate wins, a tie goes to the master that did not own the last access.
  assign idle        = (state == IDLE);
  assign slot_prot   = PROT_EN && slot_v && slot_we && (slot_addr >= PROT_BASE);
  assign i2c_cand    = slot_v && !slot_prot;
  assign pick_i2c    = i2c_cand && (!host_req || last_host);
  assign pick_host   = host_req && (!i2c_cand || !last_host);
  assign slot_take   = idle && (pick_i2c || slot_prot);
  assign strobe_one  = i2c_wr_en ^ i2c_rd_en;
  assign strobe_both = i2c_wr_en & i2c_rd_en;

  assign i2c_busy = slot_v | (!idle && !own_host);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot_v      <= 1'b0;
      slot_we     <= 1'b0;
      slot_addr   <= '0;
      slot_wdata  <= '0;
      own_host    <= 1'b0;
      last_host   <= 1'b1;
      cnt         <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      host_gnt    <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      i2c_rdata   <= '0;
      i2c_rvalid  <= 1'b0;
      i2c_ovf     <= 1'b0;
    end else begin
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      host_gnt    <= 1'b0;
      host_rvalid <= 1'b0;
      i2c_rvalid  <= 1'b0;

      // Slot: a strobe landing in the consuming cycle refills it; otherwise a full slot drops it.
      if (slot_take) slot_v <= 1'b0;
      if (strobe_one && (!slot_v || slot_take)) begin
        slot_v    <= 1'b1;
        slot_we   <= i2c_wr_en;
        slot_addr <= i2c_addr;
        if (i2c_wr_en) slot_wdata <= i2c_wdata;
      end
      if (strobe_both || (strobe_one && slot_v && !slot_take) || (idle && slot_prot))
        i2c_ovf <= 1'b1;

      case (state)
        IDLE: begin
          if (pick_i2c || pick_host) begin
            state     <= ISSUE;
            own_host  <= pick_host;
            last_host <= pick_host;
            host_gnt  <= pick_host;
            if (pick_host) begin
              reg_addr  <= host_addr;
              reg_wdata <= host_wdata;
              reg_wr_en <= host_we;
              reg_rd_en <= !host_we;
            end else begin
              reg_addr  <= slot_addr;
              reg_wdata <= slot_wdata;
              reg_wr_en <= slot_we;
              reg_rd_en <= !slot_we;
            end
          end
        end
        ISSUE: begin
          if (reg_wr_en) begin
            state <= IDLE;
          end else begin
            state <= RDWAIT;
            cnt   <= CNT_W'(RD_LAT - 1);
          end
        end
        RDWAIT: begin
          // The last wait cycle is the one where the bank data is valid.
          if (cnt == '0) begin
            state <= IDLE;
            if (own_host) begin
              host_rdata  <= reg_rdata;
              host_rvalid <= 1'b1;
            end else begin
              i2c_rdata  <= reg_rdata;
              i2c_rvalid <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
